// File: rtl/spi_mem_ctrl_if.sv
// Request/response and serial-link signals of spi_mem_ctrl.
// "slave" is the controller's view; "master" is the environment's.
interface spi_mem_ctrl_if;
    logic       req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       err;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       ready;
    logic       op_done;

    modport slave (
        input  req, wr, addr, wdata, miso, ready, op_done,
        output busy, done, rdata, err, cs, mosi
    );

    modport master (
        output req, wr, addr, wdata, miso, ready, op_done,
        input  busy, done, rdata, err, cs, mosi
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// Serialises parallel read/write requests onto cs/mosi for spi_mem,
// collects read data from miso and reports done/err.
module spi_mem_ctrl #(
    parameter int MEM_DEPTH = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    spi_mem_ctrl_if.slave io_bus
);
    localparam int CW = $clog2(TIMEOUT + 16) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_SHIFT,
        S_WAIT_READY,
        S_RECV,
        S_WAIT_DONE
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_wr, w_wr;
    logic [15:0]   r_sh, w_sh;
    logic [7:0]    r_rx, w_rx;
    logic [7:0]    r_rdata, w_rdata;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_err, w_err;
    logic          r_cs, w_cs;
    logic          r_mosi, w_mosi;
    logic          w_addr_ok;
    logic          w_last_bit;
    logic          w_tmo;

    assign w_addr_ok  = {1'b0, io_bus.addr} < 9'(MEM_DEPTH);
    assign w_last_bit = r_wr ? (r_cnt == CW'(16)) : (r_cnt == CW'(8));
    assign w_tmo      = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_wr    = r_wr;
        w_sh    = r_sh;
        w_rx    = r_rx;
        w_rdata = r_rdata;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_cs    = r_cs;
        w_mosi  = r_mosi;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.req) begin
                    if (w_addr_ok) begin
                        w_state = S_OPCODE;
                        w_cnt   = '0;
                        w_wr    = io_bus.wr;
                        w_sh    = {io_bus.wdata, io_bus.addr};
                        w_busy  = 1'b1;
                        w_cs    = 1'b0;
                        w_mosi  = io_bus.wr;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            // opcode is held two cycles: slave leaves idle, then samples it
            S_OPCODE: begin
                if (r_cnt == '0) begin
                    w_cnt = CW'(1);
                end else begin
                    w_state = S_SHIFT;
                    w_mosi  = r_sh[0];
                    w_sh    = {1'b0, r_sh[15:1]};
                    w_cnt   = CW'(1);
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_cs    = 1'b1;
                    w_mosi  = 1'b0;
                    w_cnt   = '0;
                    w_state = r_wr ? S_WAIT_DONE : S_WAIT_READY;
                end else begin
                    w_mosi = r_sh[0];
                    w_sh   = {1'b0, r_sh[15:1]};
                    w_cnt  = r_cnt + CW'(1);
                end
            end
            S_WAIT_READY: begin
                if (io_bus.ready) begin
                    w_state = S_RECV;
                    w_cnt   = '0;
                end else if (w_tmo) begin
                    w_err   = 1'b1;
                    w_busy  = 1'b0;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_RECV: begin
                w_rx = {io_bus.miso, r_rx[7:1]};
                if (r_cnt == CW'(7)) begin
                    w_state = S_WAIT_DONE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (io_bus.op_done) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                    if (!r_wr) w_rdata = r_rx;
                end else if (w_tmo) begin
                    w_err   = 1'b1;
                    w_busy  = 1'b0;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_sh    <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_wr    <= w_wr;
            r_sh    <= w_sh;
            r_rx    <= w_rx;
            r_rdata <= w_rdata;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_cs    <= w_cs;
            r_mosi  <= w_mosi;
        end
    end

    assign io_bus.busy  = r_busy;
    assign io_bus.done  = r_done;
    assign io_bus.rdata = r_rdata;
    assign io_bus.err   = r_err;
    assign io_bus.cs    = r_cs;
    assign io_bus.mosi  = r_mosi;
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: cycle-level spi_mem slave model plus a
// memory/last-read reference model, vector table, random ops, corner cases.
module tb_spi_mem_ctrl;
    localparam int MEM_DEPTH = 32;
    localparam int TIMEOUT   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_mem_ctrl_if bus ();

    spi_mem_ctrl #(
        .MEM_DEPTH(MEM_DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       e_err;
        logic [7:0] e_rd;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] slv_mem [MEM_DEPTH];
    logic [7:0] ref_mem [MEM_DEPTH];
    logic [7:0] last_rd;
    logic       slv_hold = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    // Slave: counts cycles from the first cs-low cycle (C0)
    initial begin : slave
        int         sc;
        logic       op_w;
        logic [7:0] sa, sd, sq;
        sc = -1; op_w = 1'b0; sa = '0; sd = '0; sq = '0;
        bus.ready = 1'b0; bus.op_done = 1'b0; bus.miso = 1'b0;
        foreach (slv_mem[i]) slv_mem[i] = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.ready = 1'b0; bus.op_done = 1'b0; bus.miso = 1'b0;
            if (rst || slv_hold) begin
                sc = -1;
            end else if (sc < 0) begin
                if (!bus.cs) sc = 0;
            end else begin
                sc++;
                if (sc == 1) op_w = bus.mosi;
                else if (sc <= 9) sa = {bus.mosi, sa[7:1]};
                else if (op_w) begin
                    if (sc <= 17) sd = {bus.mosi, sd[7:1]};
                    else if (sc == 19) begin
                        bus.op_done = 1'b1;
                        slv_mem[sa[4:0]] = sd;
                        sc = -1;
                    end
                end else begin
                    if (sc == 11) begin
                        bus.ready = 1'b1;
                        sq = slv_mem[sa[4:0]];
                    end else if (sc >= 12 && sc <= 19) begin
                        bus.miso = sq[0];
                        sq = {1'b0, sq[7:1]};
                    end else if (sc == 20) begin
                        bus.op_done = 1'b1;
                        sc = -1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // Issue one request at the current cycle and follow it to done/err
    task automatic do_op(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input bit stalled,
                         output logic got_err, output logic [7:0] got_rd);
        logic q[$];
        int   t_done, t_err, b0, got_bits, len;
        bit   bad;
        logic [17:0] exp_bits;
        bad      = int'(a) >= MEM_DEPTH;
        exp_bits = {d, a, w, w};
        len      = w ? 18 : 10;
        t_done   = -1;
        t_err    = -1;
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 1'b0;
        b0 = int'(bus.busy);
        for (int n = 0; n < 200; n++) begin
            if (!bus.cs) q.push_back(bus.mosi);
            if (bus.done && t_done < 0) t_done = n;
            if (bus.err && t_err < 0) t_err = n;
            if (t_done >= 0 || t_err >= 0) break;
            @(posedge clk); #1;
        end
        got_err = (t_err >= 0);
        got_rd  = bus.rdata;
        got_bits = 0;
        for (int k = 0; k < q.size() && k < 18; k++)
            got_bits |= int'(q[k]) << k;
        chk("busy_c0", b0, int'(!bad));
        chk("busy_end", int'(bus.busy), 0);
        if (bad) begin
            chk("bad_err_cycle", t_err, 0);
            chk("bad_cs_low", q.size(), 0);
            chk("bad_no_done", t_done, -1);
        end else begin
            if (stalled) begin
                chk("timeout_cycle", t_err, 10 + TIMEOUT);
                chk("timeout_no_done", t_done, -1);
            end else begin
                chk("done_cycle", t_done, w ? 20 : 21);
                chk("no_err", t_err, -1);
            end
            chk("cs_low", q.size(), len);
            chk("mosi_bits", got_bits, int'(exp_bits) & ((1 << len) - 1));
        end
        if (!bad && !stalled) begin
            if (w) ref_mem[a[4:0]] = d;
            else last_rd = ref_mem[a[4:0]];
        end
        chk("rdata", int'(got_rd), int'(last_rd));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic       ge;
        logic [7:0] gr;
        int         falls, dones, errs, seen;
        logic       prev;

        tbl[0] = '{1'b1, 8'h05, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h05, 8'h00, 1'b0, 8'hA5};
        tbl[2] = '{1'b1, 8'h20, 8'h77, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'hA5};
        tbl[4] = '{1'b1, 8'h1F, 8'h3C, 1'b0, 8'hA5};
        tbl[5] = '{1'b0, 8'h1F, 8'h00, 1'b0, 8'h3C};
        tbl[6] = '{1'b1, 8'h00, 8'h5A, 1'b0, 8'h3C};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h5A};
        tbl[8] = '{1'b0, 8'h1F, 8'h00, 1'b0, 8'h3C};

        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        last_rd = 8'h00;
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", int'(bus.cs), 1);
        chk("rst_mosi", int'(bus.mosi), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_rdata", int'(bus.rdata), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, ge, gr);
            chk($sformatf("tbl%0d_err", i), int'(ge), int'(tbl[i].e_err));
            chk($sformatf("tbl%0d_rdata", i), int'(gr), int'(tbl[i].e_rd));
        end

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 39)),
                  8'($urandom), 1'b0, ge, gr);
        end

        // write then a read requested in the write's done cycle, req held
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 8'd31; bus.wdata = 8'h3C;
        falls = 0; dones = 0; errs = 0; prev = 1'b1; gr = '0;
        for (int n = 0; n < 120 && dones < 2; n++) begin
            @(posedge clk); #1;
            if (prev && !bus.cs) falls++;
            prev = bus.cs;
            if (bus.err) errs++;
            if (bus.done) begin
                dones++;
                if (dones == 1) bus.wr = 1'b0;
                else begin
                    gr = bus.rdata;
                    bus.req = 1'b0;
                end
            end
        end
        bus.req = 1'b0;
        ref_mem[31] = 8'h3C;
        last_rd = ref_mem[31];
        repeat (30) begin
            @(posedge clk); #1;
            if (prev && !bus.cs) falls++;
            prev = bus.cs;
            if (bus.err) errs++;
            if (bus.done) dones++;
        end
        chk("b2b_dones", dones, 2);
        chk("b2b_cs_falls", falls, 2);
        chk("b2b_errs", errs, 0);
        chk("b2b_rdata", int'(gr), int'(last_rd));

        // slave held in reset: read must time out in WAIT_READY
        slv_hold = 1'b1;
        do_op(1'b0, 8'h05, 8'h00, 1'b1, ge, gr);
        chk("timeout_err", int'(ge), 1);
        slv_hold = 1'b0;
        @(posedge clk); #1;

        // reset in C5 of a write
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 8'd2; bus.wdata = 8'h77;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("c5_cs_low", int'(bus.cs), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_cs", int'(bus.cs), 1);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_err", int'(bus.err), 0);
        last_rd = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done || bus.err || !bus.cs) seen++;
        end
        chk("mid_rst_quiet", seen, 0);
        do_op(1'b1, 8'd2, 8'h11, 1'b0, ge, gr);
        do_op(1'b0, 8'd2, 8'h00, 1'b0, ge, gr);
        chk("mid_rst_readback", int'(gr), 8'h11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
